// File: rtl/alu_pkg.sv
// Opcode constants and writeback state encoding shared between the ALU and
// its result sink.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BEAT_LO = 2'b01,
        ST_BEAT_HI = 2'b10
    } wb_state_e;

    // Mul and Div produce a HI/remainder half that needs its own beat.
    function automatic logic is_two_beat(input logic [4:0] op);
        logic two_beat;
        case (op)
            OP_MUL:  two_beat = 1'b1;
            OP_DIV:  two_beat = 1'b1;
            default: two_beat = 1'b0;
        endcase
        return two_beat;
    endfunction

endpackage

// File: rtl/alu_result_sink.sv
// Splits a 2*DATA_W ALU result into one or two writeback beats (LO, then HI).
// Define ALU_WB_BYPASS_EN to accept a new result in the cycle the last beat retires.
module alu_result_sink
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [4:0]            opcode,
    input  logic [2*DATA_W-1:0]   result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_sel,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_last,
    output logic [15:0]           op_count
);

    wb_state_e             r_state;
    logic [2*DATA_W-1:0]   r_capture;
    logic                  r_two_beat;
    logic                  r_wb_valid;
    logic                  r_wb_sel;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_wb_last;
    logic [15:0]           r_op_count;

    logic                  w_retire;
    logic                  w_accept;
    logic                  w_two_beat;

    assign w_retire   = r_wb_valid & wb_ready & r_wb_last;
    assign w_two_beat = is_two_beat(opcode);

`ifdef ALU_WB_BYPASS_EN
    assign res_ready = (r_state == ST_IDLE) | w_retire;
`else
    assign res_ready = (r_state == ST_IDLE);
`endif

    assign w_accept = res_valid & res_ready;

    assign wb_valid = r_wb_valid;
    assign wb_sel   = r_wb_sel;
    assign wb_data  = r_wb_data;
    assign wb_last  = r_wb_last;
    assign op_count = r_op_count;

    // Writeback FSM; beat outputs are loaded on the transition into each beat state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_capture  <= '0;
            r_two_beat <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_wb_data  <= '0;
            r_wb_last  <= 1'b0;
            r_op_count <= 16'h0000;
        end else begin
            if (w_retire) begin
                r_op_count <= r_op_count + 16'h0001;
            end else begin
                r_op_count <= r_op_count;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_BEAT_LO;
                        r_capture  <= result;
                        r_two_beat <= w_two_beat;
                        r_wb_valid <= 1'b1;
                        r_wb_sel   <= 1'b0;
                        r_wb_data  <= result[DATA_W-1:0];
                        r_wb_last  <= ~w_two_beat;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BEAT_LO: begin
                    if (wb_ready && r_two_beat) begin
                        r_state   <= ST_BEAT_HI;
                        r_wb_sel  <= 1'b1;
                        r_wb_data <= r_capture[2*DATA_W-1:DATA_W];
                        r_wb_last <= 1'b1;
                    end else if (wb_ready && w_accept) begin
                        r_state    <= ST_BEAT_LO;
                        r_capture  <= result;
                        r_two_beat <= w_two_beat;
                        r_wb_sel   <= 1'b0;
                        r_wb_data  <= result[DATA_W-1:0];
                        r_wb_last  <= ~w_two_beat;
                    end else if (wb_ready) begin
                        r_state    <= ST_IDLE;
                        r_wb_valid <= 1'b0;
                        r_wb_sel   <= 1'b0;
                        r_wb_last  <= 1'b0;
                    end else begin
                        r_state <= ST_BEAT_LO;
                    end
                end
                ST_BEAT_HI: begin
                    // w_accept can only be set here in the bypass build.
                    if (wb_ready && w_accept) begin
                        r_state    <= ST_BEAT_LO;
                        r_capture  <= result;
                        r_two_beat <= w_two_beat;
                        r_wb_sel   <= 1'b0;
                        r_wb_data  <= result[DATA_W-1:0];
                        r_wb_last  <= ~w_two_beat;
                    end else if (wb_ready) begin
                        r_state    <= ST_IDLE;
                        r_wb_valid <= 1'b0;
                        r_wb_sel   <= 1'b0;
                        r_wb_last  <= 1'b0;
                    end else begin
                        r_state <= ST_BEAT_HI;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wb_valid <= 1'b0;
                    r_wb_sel   <= 1'b0;
                    r_wb_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
